// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master.
// State codes double as the state_dbg LED encoding.
package i2c_pkg;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_START    = 4'd1;
  localparam logic [3:0] ST_TX_ADDR  = 4'd2;
  localparam logic [3:0] ST_ACK_ADDR = 4'd3;
  localparam logic [3:0] ST_TX_MEM   = 4'd4;
  localparam logic [3:0] ST_ACK_MEM  = 4'd5;
  localparam logic [3:0] ST_TX_DATA  = 4'd6;
  localparam logic [3:0] ST_ACK_DATA = 4'd7;
  localparam logic [3:0] ST_RX_DATA  = 4'd8;
  localparam logic [3:0] ST_TX_NACK  = 4'd9;
  localparam logic [3:0] ST_STOP     = 4'd10;

  typedef enum logic [3:0] {
    S_IDLE     = ST_IDLE,
    S_START    = ST_START,
    S_TX_ADDR  = ST_TX_ADDR,
    S_ACK_ADDR = ST_ACK_ADDR,
    S_TX_MEM   = ST_TX_MEM,
    S_ACK_MEM  = ST_ACK_MEM,
    S_TX_DATA  = ST_TX_DATA,
    S_ACK_DATA = ST_ACK_DATA,
    S_RX_DATA  = ST_RX_DATA,
    S_TX_NACK  = ST_TX_NACK,
    S_STOP     = ST_STOP
  } state_t;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h7F;

  // SCL is high in the second half of every bit slot.
  function automatic logic bit_scl(input logic [1:0] ph);
    return ph[1];
  endfunction

endpackage

// File: rtl/i2c_qtick.sv
// Quarter-period timebase: one-cycle tick per QUARTER clocks plus
// a 2-bit phase; held cleared while run is low.
module i2c_qtick
  import i2c_pkg::*;
#(
  parameter int QUARTER = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic       tick,
  output logic [1:0] phase
);

  localparam int CW = (QUARTER > 1) ? $clog2(QUARTER) : 1;

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == CW'(QUARTER - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= Q0;
    end else if (!run) begin
      cnt   <= '0;
      phase <= Q0;
    end else if (tick) begin
      cnt   <= '0;
      phase <= phase + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, dev addr+RW, mem addr, one data
// byte written or read, STOP.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int QUARTER = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] mem_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [3:0] state_dbg,
  output logic       scl,
  inout  wire        sda
);

  state_t      state_q;
  state_t      state_d;
  logic        tick;
  logic [1:0]  phase;
  logic        slot_end;
  logic        accept;
  logic        last_bit;
  logic [7:0]  sh;
  logic [2:0]  bitcnt;
  logic        rw_q;
  logic [7:0]  mem_q;
  logic [7:0]  wr_q;
  logic        sda_s1;
  logic        sda_s;
  logic        scl_c;
  logic        sda_oe;

  i2c_qtick #(.QUARTER(QUARTER)) u_qtick (
    .clk   (clk),
    .rst   (rst),
    .run   (busy),
    .tick  (tick),
    .phase (phase)
  );

  assign busy      = (state_q != S_IDLE);
  assign accept    = (state_q == S_IDLE) && start;
  assign slot_end  = tick && (phase == Q3);
  assign last_bit  = (bitcnt == 3'd7);
  assign state_dbg = state_q;
  assign scl       = scl_c;
  assign sda       = sda_oe ? 1'b0 : 1'bz;

  // The bus line is asynchronous to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sda_s1 <= 1'b1;
      sda_s  <= 1'b1;
    end else begin
      sda_s1 <= sda;
      sda_s  <= sda_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    scl_c   = 1'b1;
    sda_oe  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_START;
      end
      S_START: begin
        sda_oe = phase[1];
        if (slot_end) state_d = S_TX_ADDR;
      end
      S_TX_ADDR: begin
        scl_c  = bit_scl(phase);
        sda_oe = ~sh[7];
        if (slot_end && last_bit) state_d = S_ACK_ADDR;
      end
      S_ACK_ADDR: begin
        scl_c = bit_scl(phase);
        if (slot_end) state_d = sda_s ? S_STOP : S_TX_MEM;
      end
      S_TX_MEM: begin
        scl_c  = bit_scl(phase);
        sda_oe = ~sh[7];
        if (slot_end && last_bit) state_d = S_ACK_MEM;
      end
      S_ACK_MEM: begin
        scl_c = bit_scl(phase);
        if (slot_end) begin
          if (sda_s)     state_d = S_STOP;
          else if (rw_q) state_d = S_RX_DATA;
          else           state_d = S_TX_DATA;
        end
      end
      S_TX_DATA: begin
        scl_c  = bit_scl(phase);
        sda_oe = ~sh[7];
        if (slot_end && last_bit) state_d = S_ACK_DATA;
      end
      S_ACK_DATA: begin
        scl_c = bit_scl(phase);
        if (slot_end) state_d = S_STOP;
      end
      S_RX_DATA: begin
        scl_c = bit_scl(phase);
        if (slot_end && last_bit) state_d = S_TX_NACK;
      end
      S_TX_NACK: begin
        scl_c = bit_scl(phase);
        if (slot_end) state_d = S_STOP;
      end
      S_STOP: begin
        scl_c  = (phase != Q0);
        sda_oe = (phase != Q3);
        if (slot_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh      <= '0;
      bitcnt  <= '0;
      rw_q    <= 1'b0;
      mem_q   <= '0;
      wr_q    <= '0;
      rd_data <= '0;
      ack_err <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        sh      <= {dev_addr, rw};
        rw_q    <= rw;
        mem_q   <= mem_addr;
        wr_q    <= wr_data;
        bitcnt  <= '0;
        ack_err <= 1'b0;
      end else if (slot_end) begin
        unique case (state_q)
          S_TX_ADDR, S_TX_MEM, S_TX_DATA: begin
            sh     <= {sh[6:0], 1'b0};
            bitcnt <= bitcnt + 3'd1;
          end
          S_RX_DATA: begin
            sh     <= {sh[6:0], sda_s};
            bitcnt <= bitcnt + 3'd1;
            if (last_bit) rd_data <= {sh[6:0], sda_s};
          end
          S_ACK_ADDR: begin
            if (sda_s) ack_err <= 1'b1;
            else       sh      <= mem_q;
          end
          S_ACK_MEM: begin
            if (sda_s) ack_err <= 1'b1;
            else       sh      <= wr_q;
          end
          S_ACK_DATA: begin
            if (sda_s) ack_err <= 1'b1;
          end
          S_STOP: done <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master with a clocked memory-slave model on the bus.
// The slave NACKs any memory address >= 0xF0.
module tb_i2c_master;

  localparam int Q     = 4;
  localparam int LIMIT = 200 * Q;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] dev_addr = 7'h00;
  logic [7:0] mem_addr = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic [3:0] state_dbg;
  logic       scl;
  wire        sda;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  i2c_master #(.QUARTER(Q)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rw        (rw),
    .dev_addr  (dev_addr),
    .mem_addr  (mem_addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .ack_err   (ack_err),
    .state_dbg (state_dbg),
    .scl       (scl),
    .sda       (sda)
  );

  pullup (sda);

  // Slave model
  logic       s_rst = 1'b1;
  logic       s_act = 1'b0;
  logic       s_drv = 1'b0;
  logic       s_seen = 1'b0;
  logic       s_rw = 1'b0;
  logic [7:0] s_sh = 8'h00;
  logic [7:0] s_addr = 8'h00;
  int         s_bit = 0;
  int         s_byte = 0;
  logic       scl_p = 1'b1;
  logic       sda_p = 1'b1;
  logic       drv_p = 1'b0;
  logic [7:0] mem [256];
  int         stop_cnt = 0;
  int         nack_cnt = 0;
  int         done_cnt = 0;

  assign sda = s_drv ? 1'b0 : 1'bz;

  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  always @(posedge clk) begin
    scl_p <= scl;
    sda_p <= sda;
    drv_p <= s_drv;
    if (s_rst) begin
      s_act  <= 1'b0;
      s_drv  <= 1'b0;
      s_seen <= 1'b0;
    end else if (scl_p && scl && sda_p && !sda && !s_drv && !drv_p) begin
      s_act  <= 1'b1;
      s_bit  <= 0;
      s_byte <= 0;
      s_seen <= 1'b0;
    end else if (scl_p && scl && !sda_p && sda && !s_drv && !drv_p) begin
      s_act    <= 1'b0;
      stop_cnt <= stop_cnt + 1;
    end else if (s_act && scl && !scl_p) begin
      s_seen <= 1'b1;
      if (s_bit < 8) begin
        if (s_byte == 2 && s_rw) s_drv <= ~mem[s_addr][3'(7 - s_bit)];
        else s_sh <= {s_sh[6:0], sda};
      end else begin
        case (s_byte)
          0: begin
            s_rw <= s_sh[0];
            if (s_sh[7:1] == 7'h7F) s_drv <= 1'b1;
            else s_act <= 1'b0;
          end
          1: begin
            s_addr <= s_sh;
            if (s_sh < 8'hF0) s_drv <= 1'b1;
            else s_act <= 1'b0;
          end
          default: begin
            if (!s_rw) begin
              mem[s_addr] <= s_sh;
              s_drv <= 1'b1;
            end else if (sda) begin
              nack_cnt <= nack_cnt + 1;
            end
          end
        endcase
      end
    end else if (s_act && !scl && scl_p) begin
      s_drv <= 1'b0;
      if (s_seen) begin
        s_seen <= 1'b0;
        if (s_bit == 8) begin
          s_bit  <= 0;
          s_byte <= s_byte + 1;
        end else begin
          s_bit <= s_bit + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Request one transaction; returns edges from accept until done.
  task automatic launch(input logic r, input logic [6:0] d,
                        input logic [7:0] m, input logic [7:0] w,
                        output int n);
    rw = r;
    dev_addr = d;
    mem_addr = m;
    wr_data = w;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_rise", int'(busy), 1);
    n = 0;
    while (!done && n < LIMIT) begin
      @(posedge clk);
      #1 n++;
    end
    chk("done_seen", int'(done), 1);
    chk("busy_fall", int'(busy), 0);
  endtask

  typedef struct {
    logic       rw;
    logic [6:0] dev;
    logic [7:0] mem;
    logic [7:0] wd;
    logic       exp_err;
    int         exp_q;
    logic       chk_rd;
    logic [7:0] exp_rd;
    logic       chk_mem;
    logic [7:0] exp_mem;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int n;
    int n2;
    int base_done;
    int base_stop;
    int base_nack;
    int k;

    vecs[0] = '{1'b0, 7'h7F, 8'h03, 8'hA5, 1'b0, 116, 1'b0, 8'h00, 1'b1, 8'hA5};
    vecs[1] = '{1'b1, 7'h7F, 8'h03, 8'h00, 1'b0, 116, 1'b1, 8'hA5, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 7'h12, 8'h03, 8'h77, 1'b1,  44, 1'b0, 8'h00, 1'b1, 8'hA5};
    vecs[3] = '{1'b1, 7'h12, 8'h03, 8'h00, 1'b1,  44, 1'b1, 8'hA5, 1'b0, 8'h00};
    vecs[4] = '{1'b0, 7'h7F, 8'hF5, 8'h66, 1'b1,  80, 1'b0, 8'h00, 1'b1, 8'h00};
    vecs[5] = '{1'b0, 7'h7F, 8'h40, 8'h5A, 1'b0, 116, 1'b0, 8'h00, 1'b1, 8'h5A};
    vecs[6] = '{1'b1, 7'h7F, 8'h40, 8'h00, 1'b0, 116, 1'b1, 8'h5A, 1'b0, 8'h00};

    idle(3);
    chk("rst_scl", int'(scl), 1);
    chk("rst_sda", int'(sda), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ackerr", int'(ack_err), 0);
    chk("rst_rddata", int'(rd_data), 0);
    chk("rst_state", int'(state_dbg), 0);
    rst = 1'b0;
    s_rst = 1'b0;
    idle(3);

    for (int i = 0; i < 7; i++) begin
      base_done = done_cnt;
      base_stop = stop_cnt;
      base_nack = nack_cnt;
      launch(vecs[i].rw, vecs[i].dev, vecs[i].mem, vecs[i].wd, n);
      chk($sformatf("v%0d_cycles", i), n, vecs[i].exp_q * Q);
      chk($sformatf("v%0d_ackerr", i), int'(ack_err), int'(vecs[i].exp_err));
      chk($sformatf("v%0d_scl", i), int'(scl), 1);
      chk($sformatf("v%0d_sda", i), int'(sda), 1);
      if (vecs[i].chk_rd)
        chk($sformatf("v%0d_rddata", i), int'(rd_data), int'(vecs[i].exp_rd));
      if (vecs[i].chk_mem)
        chk($sformatf("v%0d_mem", i), int'(mem[vecs[i].mem]),
            int'(vecs[i].exp_mem));
      idle(3);
      chk($sformatf("v%0d_donecnt", i), done_cnt - base_done, 1);
      chk($sformatf("v%0d_stop", i), stop_cnt - base_stop, 1);
      if (vecs[i].rw && !vecs[i].exp_err)
        chk($sformatf("v%0d_mnack", i), nack_cnt - base_nack, 1);
    end

    // start pulsed while busy must be ignored
    base_done = done_cnt;
    fork
      launch(1'b0, 7'h7F, 8'h05, 8'h11, n);
      begin
        idle(100);
        rw = 1'b1;
        mem_addr = 8'h06;
        wr_data = 8'h99;
        start = 1'b1;
        idle(1);
        start = 1'b0;
      end
    join
    chk("busy_start_cycles", n, 116 * Q);
    chk("busy_start_ackerr", int'(ack_err), 0);
    chk("busy_start_mem5", int'(mem[5]), 8'h11);
    chk("busy_start_mem6", int'(mem[6]), 8'h00);
    idle(3);
    chk("busy_start_donecnt", done_cnt - base_done, 1);

    // async reset in the middle of TX_MEM
    rw = 1'b0;
    dev_addr = 7'h7F;
    mem_addr = 8'h07;
    wr_data = 8'hEE;
    start = 1'b1;
    idle(1);
    start = 1'b0;
    k = 0;
    while (state_dbg != 4'd4 && k < LIMIT) begin
      idle(1);
      k++;
    end
    chk("reach_tx_mem", int'(state_dbg), 4);
    idle(5 * Q);
    rst = 1'b1;
    s_rst = 1'b1;
    #1;
    chk("mid_rst_scl", int'(scl), 1);
    chk("mid_rst_sda", int'(sda), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_state", int'(state_dbg), 0);
    idle(2);
    rst = 1'b0;
    s_rst = 1'b0;
    idle(3);
    launch(1'b0, 7'h7F, 8'h07, 8'h3C, n);
    chk("post_rst_cycles", n, 116 * Q);
    chk("post_rst_ackerr", int'(ack_err), 0);
    chk("post_rst_mem7", int'(mem[7]), 8'h3C);
    idle(3);

    // back-to-back, second start during the done cycle
    base_done = done_cnt;
    launch(1'b0, 7'h7F, 8'h00, 8'h01, n);
    launch(1'b0, 7'h7F, 8'h07, 8'hFE, n2);
    chk("b2b_cycles1", n, 116 * Q);
    chk("b2b_cycles2", n2, 116 * Q);
    chk("b2b_mem0", int'(mem[0]), 8'h01);
    chk("b2b_mem7", int'(mem[7]), 8'hFE);
    idle(3);
    chk("b2b_donecnt", done_cnt - base_done, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
